move_control: RTL and testbench
===============================

# move_control

Address sequencer for the Sobel edge-detection datapath. It walks a 3x3 window's top-left read address, and the matching write address, across a width x length image in serpentine order: right along a row, down one row, left along the next row, and so on. It reports the current horizontal direction, pulses `move_done` after each step, and flags `all_done` once the final window position is reached.

## Interface
Parameters: none. Widths are fixed.

Ports:
- `clk` in 1: single clock, rising edge.
- `n_reset` in 1: reset; asynchronous, active-high (asserted = 1, despite the name).
- `width` in 12: image width in pixels.
- `length` in 12: image height in rows.
- `initial_addr_r` in 8: read base address, the top-left pixel.
- `initial_addr_w` in 8: write base address.
- `load_initial` in 1: synchronous load or restart; level-sensitive.
- `start_move` in 1: step request; its rising edge triggers one move.
- `addr_r` out 8: current read address, the window top-left.
- `addr_w` out 8: current write address.
- `direction` out 2: horizontal direction. 01 = right, 11 = left; 00 and 10 are unused.
- `all_done` out 1: window is at the final position.
- `move_done` out 1: one-cycle pulse after each executed move.

## Operation
- Internal state: column counter `col` (12 bit), row counter `row` (12 bit), and `start_q` (registered `start_move`). A move fires when `start_move & ~start_q`.
- Valid window columns are 0..width-3 and valid rows are 0..length-3.
- `load_initial` = 1 at a clock edge:
  - `addr_r` ← `initial_addr_r`, `addr_w` ← `initial_addr_w`.
  - `col` ← 0, `row` ← 0, `direction` ← 01.
  - `move_done` ← 0.
  - `all_done` ← 1 if width < 3, length < 3, or width = 3 and length = 3; otherwise 0.
  - Load has priority over a move in the same cycle.
- Move, when not done. It is one of three cases, with both addresses changed by the same offset:
  - Right (direction 01, col < width-3): addresses +1, col+1.
  - Left (direction 11, col > 0): addresses −1, col−1.
  - At the edge column in the current direction and row < length-3: addresses + `width` (truncated to 8 bits), row+1, direction toggles 01↔11. The column is unchanged.
- After any move, `all_done` ← 1 if the new position is final: row = length-3 and col is at the edge for the new direction.
- A move request while `all_done` = 1 is ignored; no address change and no `move_done`.
- Address arithmetic is modulo 256 and wraps silently.
- `width` and `length` must stay stable between a load and `all_done`.

## Timing
- Reset values: `addr_r` 0, `addr_w` 0, `direction` 01, `all_done` 0, `move_done` 0, `col` and `row` 0, `start_q` 0.
- Move latency: the addresses update at the first rising clock edge where `start_move` = 1 and `start_q` = 0. `move_done` is high for exactly the following cycle.
- Holding `start_move` high for many cycles produces exactly one move. It must return to 0 for at least one sampled edge before the next move.
- `load_initial` held high for multiple cycles keeps reloading; no moves occur during that time.
- All outputs are registered.
- Reset mid-operation: all state returns to reset values immediately, asynchronously.

## Structure
- Package `move_control_pkg`:
  - Direction constants `DIR_RIGHT = 2'b01`, `DIR_LEFT = 2'b11`.
  - Address width (8) and dimension width (12) constants.
- One sub-module, `rise_detect`: registers `start_move` and outputs a one-cycle move strobe.
- Main block:
  - Two-state FSM: ACTIVE and DONE. DONE is entered when the final position is reached; a load leaves DONE.
  - Counters and the address/offset datapath.

## Test plan
- Reset, then load with width 5, length 5, initial_addr_r 100, initial_addr_w 0 → `addr_r` 100, `addr_w` 0, `direction` 01, `all_done` 0.
- Three single rising edges on `start_move` → addresses 101/1, then 102/2 with direction 01, then 107/7 with direction 11. `move_done` pulses once per edge.
- Hold `start_move` high for 4 cycles → exactly one move and one `move_done` pulse.
- Full 5x5 walk → address sequence 100,101,102,107,106,105,110,111,112. `all_done` rises after the 8th move; a further edge leaves 112 and produces no `move_done`.
- Width 3, length 3 load → `all_done` is 1 immediately; moves are ignored.
- Assert `n_reset` mid-walk → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/move_control_pkg.sv
// Shared constants and state type for the Sobel window address sequencer.
package move_control_pkg;
  localparam int ADDR_W = 8;
  localparam int DIM_W  = 12;

  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic {
    S_ACTIVE = 1'b0,
    S_DONE   = 1'b1
  } state_e;
endpackage

// File: rtl/move_control_rise_detect.sv
// Registers the step request and emits a one-cycle strobe on its rising edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic strobe
);
  logic start_q;
  logic start_d;

  always_comb begin
    start_d = sig_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= 1'b0;
    else     start_q <= start_d;
  end

  assign strobe = sig_in & ~start_q;
endmodule

// File: rtl/move_control.sv
// Serpentine read/write address walker for a 3x3 window over a width x length image.
// FSM: ACTIVE accepts moves; DONE holds at the final window position until reloaded.
module move_control
  import move_control_pkg::*;
(
  input  logic               clk,
  input  logic               n_reset,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   length,
  input  logic [ADDR_W-1:0]  initial_addr_r,
  input  logic [ADDR_W-1:0]  initial_addr_w,
  input  logic               load_initial,
  input  logic               start_move,
  output logic [ADDR_W-1:0]  addr_r,
  output logic [ADDR_W-1:0]  addr_w,
  output logic [1:0]         direction,
  output logic               all_done,
  output logic               move_done
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_r_q, addr_r_d;
  logic [ADDR_W-1:0]   addr_w_q, addr_w_d;
  logic [1:0]          dir_q, dir_d;
  logic [DIM_W-1:0]    col_q, col_d;
  logic [DIM_W-1:0]    row_q, row_d;
  logic                move_done_q, move_done_d;
  logic                move_stb;
  logic                exec;
  logic [ADDR_W-1:0]   offset;
  logic [DIM_W-1:0]    col_edge;
  logic [DIM_W-1:0]    row_edge;

  rise_detect u_rise (
    .clk    (clk),
    .rst    (n_reset),
    .sig_in (start_move),
    .strobe (move_stb)
  );

  assign col_edge = width - 12'd3;
  assign row_edge = length - 12'd3;

  always_comb begin
    state_d     = state_q;
    addr_r_d    = addr_r_q;
    addr_w_d    = addr_w_q;
    dir_d       = dir_q;
    col_d       = col_q;
    row_d       = row_q;
    move_done_d = 1'b0;
    exec        = 1'b0;
    offset      = '0;

    if (load_initial) begin
      addr_r_d = initial_addr_r;
      addr_w_d = initial_addr_w;
      col_d    = '0;
      row_d    = '0;
      dir_d    = DIR_RIGHT;
      // Images with fewer than two window positions are finished as soon as loaded.
      if ((width < 12'd3) || (length < 12'd3) || ((width == 12'd3) && (length == 12'd3)))
        state_d = S_DONE;
      else
        state_d = S_ACTIVE;
    end else if (move_stb && (state_q == S_ACTIVE)) begin
      if ((dir_q == DIR_RIGHT) && (col_q < col_edge)) begin
        exec   = 1'b1;
        offset = 8'd1;
        col_d  = col_q + 12'd1;
      end else if ((dir_q == DIR_LEFT) && (col_q != '0)) begin
        exec   = 1'b1;
        offset = 8'hFF;
        col_d  = col_q - 12'd1;
      end else if (row_q < row_edge) begin
        exec   = 1'b1;
        offset = width[ADDR_W-1:0];
        row_d  = row_q + 12'd1;
        dir_d  = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
      end

      if (exec) begin
        addr_r_d    = addr_r_q + offset;
        addr_w_d    = addr_w_q + offset;
        move_done_d = 1'b1;
        if ((row_d == row_edge) &&
            (((dir_d == DIR_RIGHT) && (col_d == col_edge)) ||
             ((dir_d == DIR_LEFT)  && (col_d == '0))))
          state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state_q     <= S_ACTIVE;
      addr_r_q    <= '0;
      addr_w_q    <= '0;
      dir_q       <= DIR_RIGHT;
      col_q       <= '0;
      row_q       <= '0;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_r_q    <= addr_r_d;
      addr_w_q    <= addr_w_d;
      dir_q       <= dir_d;
      col_q       <= col_d;
      row_q       <= row_d;
      move_done_q <= move_done_d;
    end
  end

  assign addr_r    = addr_r_q;
  assign addr_w    = addr_w_q;
  assign direction = dir_q;
  assign all_done  = (state_q == S_DONE);
  assign move_done = move_done_q;
endmodule

// File: tb/tb_move_control.sv
// Bench for move_control: position-index model of the serpentine walk plus literal pins.
module tb_move_control;
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [11:0] width = 12'd5;
  logic [11:0] length = 12'd5;
  logic [7:0]  initial_addr_r = 8'd0;
  logic [7:0]  initial_addr_w = 8'd0;
  logic        load_initial = 1'b0;
  logic        start_move = 1'b0;
  logic [7:0]  addr_r;
  logic [7:0]  addr_w;
  logic [1:0]  direction;
  logic        all_done;
  logic        move_done;

  int n_cmp = 0;
  int n_bad = 0;
  int md_cnt = 0;
  bit cmp_en = 1'b0;

  move_control dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .width          (width),
    .length         (length),
    .initial_addr_r (initial_addr_r),
    .initial_addr_w (initial_addr_w),
    .load_initial   (load_initial),
    .start_move     (start_move),
    .addr_r         (addr_r),
    .addr_w         (addr_w),
    .direction      (direction),
    .all_done       (all_done),
    .move_done      (move_done)
  );

  always #5 clk = ~clk;

  // Model: the window is identified by its index k along the serpentine path.
  int m_w = 5, m_l = 5, m_br = 0, m_bw = 0, m_k = 0;
  bit m_done = 0, m_md = 0, m_prev = 0;

  function automatic int cols_of(int w);
    return (w - 2 < 1) ? 1 : w - 2;
  endfunction

  function automatic int npos(int w, int l);
    int rows;
    rows = (l - 2 < 1) ? 1 : l - 2;
    return cols_of(w) * rows;
  endfunction

  function automatic int exp_addr(int base, int k, int w);
    int cw, r, c;
    cw = cols_of(w);
    r = k / cw;
    c = k % cw;
    if (r % 2 == 1) c = cw - 1 - c;
    return (base + r * w + c) & 255;
  endfunction

  function automatic int exp_dir(int k, int w);
    return (((k / cols_of(w)) % 2) == 1) ? 3 : 1;
  endfunction

  always @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      m_br <= 0; m_bw <= 0; m_k <= 0;
      m_done <= 0; m_md <= 0; m_prev <= 0;
    end else begin
      if (load_initial) begin
        m_w  <= int'(width);
        m_l  <= int'(length);
        m_br <= int'(initial_addr_r);
        m_bw <= int'(initial_addr_w);
        m_k  <= 0;
        m_md <= 0;
        m_done <= (width < 3) || (length < 3) || (width == 3 && length == 3);
      end else if (start_move && !m_prev && !m_done) begin
        m_k    <= m_k + 1;
        m_md   <= 1;
        m_done <= (m_k + 1 == npos(m_w, m_l) - 1);
      end else begin
        m_md <= 0;
      end
      m_prev <= start_move;
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model addr_r", int'(addr_r), exp_addr(m_br, m_k, m_w));
      chk("model addr_w", int'(addr_w), exp_addr(m_bw, m_k, m_w));
      chk("model direction", int'(direction), exp_dir(m_k, m_w));
      chk("model all_done", int'(all_done), int'(m_done));
      chk("model move_done", int'(move_done), int'(m_md));
    end
    if (move_done === 1'b1) md_cnt <= md_cnt + 1;
  end

  task automatic do_load(input int w, input int l, input int ar, input int aw);
    @(posedge clk); #2;
    width = 12'(w); length = 12'(l);
    initial_addr_r = 8'(ar); initial_addr_w = 8'(aw);
    load_initial = 1'b1;
    @(posedge clk); #2;
    load_initial = 1'b0;
  endtask

  task automatic pulse();
    @(posedge clk); #2 start_move = 1'b1;
    @(posedge clk); #2 start_move = 1'b0;
  endtask

  localparam int EXP_SEQ [9] = '{100, 101, 102, 107, 106, 105, 110, 111, 112};

  initial begin
    int md0;
    #1 n_reset = 1'b1;
    #2 cmp_en = 1'b1;
    chk("reset addr_r", int'(addr_r), 0);
    chk("reset direction", int'(direction), 1);
    repeat (2) @(posedge clk);
    #2 n_reset = 1'b0;

    do_load(5, 5, 100, 0);
    chk("load addr_r", int'(addr_r), 100);
    chk("load addr_w", int'(addr_w), 0);
    chk("load direction", int'(direction), 1);
    chk("load all_done", int'(all_done), 0);

    md0 = md_cnt;
    pulse();
    chk("m1 addr_r", int'(addr_r), 101);
    chk("m1 addr_w", int'(addr_w), 1);
    pulse();
    chk("m2 addr_r", int'(addr_r), 102);
    chk("m2 addr_w", int'(addr_w), 2);
    chk("m2 direction", int'(direction), 1);
    pulse();
    chk("m3 addr_r", int'(addr_r), 107);
    chk("m3 addr_w", int'(addr_w), 7);
    chk("m3 direction", int'(direction), 3);
    @(posedge clk); #2;
    chk("three pulses move_done count", md_cnt - md0, 3);

    md0 = md_cnt;
    @(posedge clk); #2 start_move = 1'b1;
    repeat (4) @(posedge clk);
    #2 start_move = 1'b0;
    @(posedge clk); #2;
    chk("hold addr_r", int'(addr_r), 106);
    chk("hold move_done count", md_cnt - md0, 1);

    do_load(5, 5, 100, 0);
    chk("walk 0 addr_r", int'(addr_r), EXP_SEQ[0]);
    for (int i = 1; i < 9; i++) begin
      pulse();
      chk($sformatf("walk %0d addr_r", i), int'(addr_r), EXP_SEQ[i]);
      if (i == 7) chk("walk all_done before last", int'(all_done), 0);
    end
    chk("walk all_done after last", int'(all_done), 1);
    @(posedge clk); #2;
    md0 = md_cnt;
    pulse();
    @(posedge clk); #2;
    chk("done extra addr_r", int'(addr_r), 112);
    chk("done extra move_done count", md_cnt - md0, 0);

    do_load(3, 3, 50, 60);
    chk("3x3 all_done", int'(all_done), 1);
    pulse();
    chk("3x3 ignored addr_r", int'(addr_r), 50);

    do_load(3, 5, 20, 40);
    pulse();
    pulse();
    chk("3x5 addr_r", int'(addr_r), 26);
    chk("3x5 all_done", int'(all_done), 1);

    do_load(10, 4, 250, 3);
    repeat (7) pulse();
    chk("wrap addr_r col7", int'(addr_r), 1);
    chk("wrap addr_w col7", int'(addr_w), 10);
    pulse();
    chk("wrap addr_r down", int'(addr_r), 11);
    chk("wrap direction down", int'(direction), 3);
    repeat (8) pulse();
    chk("wrap all_done", int'(all_done), 1);

    @(posedge clk); #2;
    width = 12'd6; length = 12'd4; initial_addr_r = 8'd30; initial_addr_w = 8'd70;
    load_initial = 1'b1; start_move = 1'b1;
    @(posedge clk); #2 start_move = 1'b0;
    @(posedge clk); #2 start_move = 1'b1;
    @(posedge clk); #2 load_initial = 1'b0; start_move = 1'b0;
    chk("load priority addr_r", int'(addr_r), 30);
    pulse();
    chk("after load priority addr_r", int'(addr_r), 31);

    do_load(5, 5, 100, 0);
    pulse();
    pulse();
    @(posedge clk); #2 start_move = 1'b1;
    @(posedge clk); #2;
    n_reset = 1'b1; start_move = 1'b0;
    #1;
    chk("async addr_r", int'(addr_r), 0);
    chk("async addr_w", int'(addr_w), 0);
    chk("async direction", int'(direction), 1);
    chk("async all_done", int'(all_done), 0);
    chk("async move_done", int'(move_done), 0);
    @(posedge clk); #2 n_reset = 1'b0;
    do_load(5, 5, 9, 200);
    pulse();
    chk("recover addr_w", int'(addr_w), 201);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
